// File: rtl/reloc_pkg.sv
// reloc_pkg: shared defaults, table entry type and reset values for reloc_unit.
package reloc_pkg;

   localparam int unsigned DEF_ADDR_W = 9;
   localparam int unsigned DEF_NPROC  = 4;

   // One relocation table entry: base added to the logical address, inclusive limit.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] base;
      logic [DEF_ADDR_W-1:0] limit;
   } reloc_entry_t;

   localparam logic [DEF_ADDR_W-1:0] RST_BASE  = '0;
   localparam logic [DEF_ADDR_W-1:0] RST_LIMIT = '1;
   localparam reloc_entry_t          RST_ENTRY = '{base: RST_BASE, limit: RST_LIMIT};

endpackage

// File: rtl/reloc_table.sv
// reloc_table: NPROC-entry base/limit register file, one write port, one
// combinational read port. Limit storage only exists with RELOC_BOUNDS_CHECK_EN.
module reloc_table
   import reloc_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NPROC  = DEF_NPROC,
   parameter int unsigned PID_W  = $clog2(NPROC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [PID_W-1:0]  wr_pid,
   input  logic [ADDR_W-1:0] wr_base,
`ifdef RELOC_BOUNDS_CHECK_EN
   input  logic [ADDR_W-1:0] wr_limit,
   output logic [ADDR_W-1:0] rd_limit_c,
`endif
   input  logic [PID_W-1:0]  rd_pid,
   output logic [ADDR_W-1:0] rd_base_c,
   output logic              rd_hit_c
);

   logic [ADDR_W-1:0] base_q [NPROC];

   // Base registers; writes to a pid outside the table match no entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NPROC; i++) base_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NPROC; i++)
            if (wr_en && (wr_pid == PID_W'(i))) base_q[i] <= wr_base;
      end
   end

`ifdef RELOC_BOUNDS_CHECK_EN
   logic [ADDR_W-1:0] limit_q [NPROC];

   // Limit registers, reset to all-ones so an unprogrammed entry never bounds-faults.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NPROC; i++) limit_q[i] <= '1;
      end else begin
         for (int unsigned i = 0; i < NPROC; i++)
            if (wr_en && (wr_pid == PID_W'(i))) limit_q[i] <= wr_limit;
      end
   end
`endif

   // Read mux by pid; rd_hit_c low when the pid names no entry.
   always_comb begin
      rd_base_c = '0;
      rd_hit_c  = 1'b0;
`ifdef RELOC_BOUNDS_CHECK_EN
      rd_limit_c = '1;
`endif
      for (int unsigned i = 0; i < NPROC; i++) begin
         if (rd_pid == PID_W'(i)) begin
            rd_base_c = base_q[i];
            rd_hit_c  = 1'b1;
`ifdef RELOC_BOUNDS_CHECK_EN
            rd_limit_c = limit_q[i];
`endif
         end
      end
   end

endmodule

// File: rtl/reloc_unit.sv
// reloc_unit: per-process base(+limit) address relocation with one registered
// valid/ready output stage and a sticky first-fault record.
// Optional feature: RELOC_BOUNDS_CHECK_EN enables limit and carry-out faults.
module reloc_unit
   import reloc_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NPROC  = DEF_NPROC,
   parameter int unsigned PID_W  = $clog2(NPROC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [PID_W-1:0]  cfg_pid,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_limit,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [PID_W-1:0]  req_pid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_fault,
   output logic              flt_sticky,
   output logic [PID_W-1:0]  flt_pid,
   input  logic              flt_clr
);

   logic [ADDR_W-1:0] base_c;
   logic              hit_c;
   logic [ADDR_W:0]   sum_c;
   logic              fault_c;
   logic              accept_c;

   logic              rsp_valid_d, rsp_fault_d, flt_sticky_d;
   logic [ADDR_W-1:0] rsp_addr_d;
   logic [PID_W-1:0]  flt_pid_d;

`ifdef RELOC_BOUNDS_CHECK_EN
   logic [ADDR_W-1:0] limit_c;
`else
   logic              unused_bits;
   assign unused_bits = ^{cfg_limit, sum_c[ADDR_W]};
`endif

   reloc_table #(.ADDR_W(ADDR_W), .NPROC(NPROC), .PID_W(PID_W)) u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (cfg_we),
      .wr_pid     (cfg_pid),
      .wr_base    (cfg_base),
`ifdef RELOC_BOUNDS_CHECK_EN
      .wr_limit   (cfg_limit),
      .rd_limit_c (limit_c),
`endif
      .rd_pid     (req_pid),
      .rd_base_c  (base_c),
      .rd_hit_c   (hit_c)
   );

   // Skid-free handshake: a new request can land whenever the output slot drains.
   assign req_ready = !rsp_valid || rsp_ready;
   assign accept_c  = req_valid && req_ready;

   // Translation and fault decision on the pre-write table contents.
   always_comb begin
      sum_c = {1'b0, req_addr} + {1'b0, base_c};
`ifdef RELOC_BOUNDS_CHECK_EN
      fault_c = !hit_c || (req_addr > limit_c) || sum_c[ADDR_W];
`else
      fault_c = !hit_c;
`endif
   end

   // Next-state for the output stage and fault record; a new fault beats flt_clr.
   always_comb begin
      rsp_valid_d  = rsp_valid;
      rsp_addr_d   = rsp_addr;
      rsp_fault_d  = rsp_fault;
      flt_sticky_d = flt_sticky;
      flt_pid_d    = flt_pid;
      if (accept_c) begin
         rsp_valid_d = 1'b1;
         rsp_addr_d  = fault_c ? '0 : sum_c[ADDR_W-1:0];
         rsp_fault_d = fault_c;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (flt_clr) begin
         flt_sticky_d = 1'b0;
         flt_pid_d    = '0;
      end
      if (accept_c && fault_c && (!flt_sticky || flt_clr)) begin
         flt_sticky_d = 1'b1;
         flt_pid_d    = req_pid;
      end
   end

   // Output and fault-status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_addr   <= '0;
         rsp_fault  <= 1'b0;
         flt_sticky <= 1'b0;
         flt_pid    <= '0;
      end else begin
         rsp_valid  <= rsp_valid_d;
         rsp_addr   <= rsp_addr_d;
         rsp_fault  <= rsp_fault_d;
         flt_sticky <= flt_sticky_d;
         flt_pid    <= flt_pid_d;
      end
   end

endmodule

// File: tb/tb_reloc_unit.sv
// tb_reloc_unit: directed vector table, corner sequences and random traffic
// against a cycle-level reference model of reloc_unit.
module tb_reloc_unit;
   import reloc_pkg::*;

   localparam int unsigned ADDR_W = DEF_ADDR_W;
   localparam int unsigned NPROC  = DEF_NPROC;
   localparam int unsigned PID_W  = $clog2(NPROC);
`ifdef RELOC_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic              clk, rst_n;
   logic              cfg_we;
   logic [PID_W-1:0]  cfg_pid;
   logic [ADDR_W-1:0] cfg_base, cfg_limit;
   logic              req_valid, req_ready;
   logic [PID_W-1:0]  req_pid;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid, rsp_ready, rsp_fault;
   logic [ADDR_W-1:0] rsp_addr;
   logic              flt_sticky, flt_clr;
   logic [PID_W-1:0]  flt_pid;

   reloc_unit #(.ADDR_W(ADDR_W), .NPROC(NPROC), .PID_W(PID_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pid(cfg_pid),
      .cfg_base(cfg_base), .cfg_limit(cfg_limit), .req_valid(req_valid),
      .req_ready(req_ready), .req_pid(req_pid), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_fault(rsp_fault), .flt_sticky(flt_sticky), .flt_pid(flt_pid),
      .flt_clr(flt_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   reloc_entry_t m_tab [NPROC];
   bit m_valid, m_fault, m_sticky;
   int m_addr, m_fpid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < int'(NPROC); i++) m_tab[i] = RST_ENTRY;
      m_valid = 0; m_fault = 0; m_addr = 0; m_sticky = 0; m_fpid = 0;
   endfunction

   // Translation from the rules: add base, fault on bad pid, over-limit or overflow.
   function automatic void translate(input int pid, input int addr, output bit f, output int pa);
      int sum;
      f  = 0;
      pa = 0;
      if (pid >= int'(NPROC)) begin
         f = 1;
         return;
      end
      sum = addr + int'(m_tab[pid].base);
      if (BC && (addr > int'(m_tab[pid].limit) || sum >= (1 << ADDR_W))) f = 1;
      pa = f ? 0 : sum % (1 << ADDR_W);
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_step();
      bit rdy, acc, f;
      int pa;
      rdy = !m_valid || rsp_ready;
      acc = req_valid && rdy;
      f = 0; pa = 0;
      if (acc) translate(int'(req_pid), int'(req_addr), f, pa);
      if (acc) begin
         m_valid = 1; m_addr = pa; m_fault = f;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      if (flt_clr) begin
         m_sticky = 0; m_fpid = 0;
      end
      if (acc && f && !m_sticky) begin
         m_sticky = 1; m_fpid = int'(req_pid);
      end
      if (cfg_we && int'(cfg_pid) < int'(NPROC)) begin
         m_tab[cfg_pid].base = cfg_base;
         if (BC) m_tab[cfg_pid].limit = cfg_limit;
      end
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, m_valid);
      chk({tag, "_req_ready"}, req_ready, !m_valid || rsp_ready);
      if (m_valid) begin
         chk({tag, "_rsp_addr"}, rsp_addr, m_addr);
         chk({tag, "_rsp_fault"}, rsp_fault, m_fault);
      end
      chk({tag, "_flt_sticky"}, flt_sticky, m_sticky);
      chk({tag, "_flt_pid"}, flt_pid, m_fpid);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   typedef struct {
      bit do_cfg;
      int cfg_pid, cfg_base, cfg_limit;
      int pid, addr;
      int exp_addr_bc, exp_fault_bc;
      int exp_addr_nb, exp_fault_nb;
   } vec_t;

   vec_t vecs [6];

   initial begin
      bit f;
      int pa, sent, cyc, held;
      int got [$];
      int expq [$];

      clk = 0; rst_n = 0;
      cfg_we = 0; cfg_pid = '0; cfg_base = '0; cfg_limit = '0;
      req_valid = 0; req_pid = '0; req_addr = '0;
      rsp_ready = 1; flt_clr = 0;
      model_reset();

      //                cfg pid  base   limit  pid addr   bc:addr flt  nb:addr flt
      vecs[0] = '{1'b0, 0, 0,     0,     2, 'h005, 'h005, 0, 'h005, 0};
      vecs[1] = '{1'b1, 1, 'h040, 'h03F, 1, 'h010, 'h050, 0, 'h050, 0};
      vecs[2] = '{1'b0, 0, 0,     0,     1, 'h040, 'h000, 1, 'h080, 0};
      vecs[3] = '{1'b1, 3, 'h1F0, 'h1FF, 3, 'h020, 'h000, 1, 'h010, 0};
      vecs[4] = '{1'b0, 0, 0,     0,     3, 'h00F, 'h1FF, 0, 'h1FF, 0};
      vecs[5] = '{1'b0, 0, 0,     0,     0, 'h1FF, 'h1FF, 0, 'h1FF, 0};

      // Reset state
      #12;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_addr", rsp_addr, 0);
      chk("rst_rsp_fault", rsp_fault, 0);
      chk("rst_flt_sticky", flt_sticky, 0);
      chk("rst_flt_pid", flt_pid, 0);
      chk("rst_req_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1;

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].do_cfg) begin
            cfg_we = 1; cfg_pid = PID_W'(vecs[i].cfg_pid);
            cfg_base = ADDR_W'(vecs[i].cfg_base); cfg_limit = ADDR_W'(vecs[i].cfg_limit);
            tick("vec_cfg");
            cfg_we = 0;
         end
         req_valid = 1; req_pid = PID_W'(vecs[i].pid); req_addr = ADDR_W'(vecs[i].addr);
         tick($sformatf("vec%0d", i));
         req_valid = 0;
         chk($sformatf("vec%0d_addr", i), rsp_addr, BC ? vecs[i].exp_addr_bc : vecs[i].exp_addr_nb);
         chk($sformatf("vec%0d_fault", i), rsp_fault, BC ? vecs[i].exp_fault_bc : vecs[i].exp_fault_nb);
         if (i == 2) begin
            chk("vec2_flt_sticky", flt_sticky, BC ? 1 : 0);
            chk("vec2_flt_pid", flt_pid, BC ? 1 : 0);
         end
      end

      // Same-cycle config write and request: old base used, new base next cycle
      cfg_we = 1; cfg_pid = 0; cfg_base = 'h100; cfg_limit = 'h1FF;
      req_valid = 1; req_pid = 0; req_addr = 'h001;
      tick("samecyc0");
      cfg_we = 0;
      chk("samecyc_old", rsp_addr, 'h001);
      tick("samecyc1");
      chk("samecyc_new", rsp_addr, 'h101);
      req_valid = 0;

      // Fault record: first fault kept, clear with simultaneous fault takes new pid
      flt_clr = 1; tick("fclr"); flt_clr = 0;
      chk("fclr_sticky", flt_sticky, 0);
      cfg_we = 1; cfg_pid = 2; cfg_base = 0; cfg_limit = 'h00F; tick("fcfg"); cfg_we = 0;
      req_valid = 1; req_pid = 1; req_addr = 'h040; tick("flt1");
      chk("flt1_pid", flt_pid, BC ? 1 : 0);
      req_pid = 2; req_addr = 'h020; tick("flt2");
      chk("flt2_pid_kept", flt_pid, BC ? 1 : 0);
      chk("flt2_sticky", flt_sticky, BC ? 1 : 0);
      flt_clr = 1; tick("flt3");
      chk("flt3_sticky", flt_sticky, BC ? 1 : 0);
      chk("flt3_pid_new", flt_pid, BC ? 2 : 0);
      req_valid = 0; tick("flt4");
      chk("flt4_cleared", flt_sticky, 0);
      flt_clr = 0;

      // Back-to-back 8 requests with rsp_ready low for cycles 3..5
      sent = 0; cyc = 0; held = 0;
      do begin
         rsp_ready = !(cyc >= 3 && cyc <= 5);
         if (sent < 8) begin
            req_valid = 1; req_pid = PID_W'(sent % 2); req_addr = ADDR_W'('h10 + sent);
         end else begin
            req_valid = 0;
         end
         #1;
         if (cyc == 3) held = int'(rsp_addr);
         if (cyc == 4 || cyc == 5) chk("bp_rsp_held", rsp_addr, held);
         if (!rsp_ready && rsp_valid) chk("bp_req_ready_low", req_ready, 0);
         if (rsp_valid && rsp_ready) got.push_back(int'(rsp_addr));
         if (req_valid && req_ready) begin
            translate(int'(req_pid), int'(req_addr), f, pa);
            expq.push_back(pa);
            sent++;
         end
         tick("bp");
         cyc++;
      end while (got.size() < 8 && cyc < 40);
      chk("bp_count", got.size(), 8);
      chk("bp_first", (got.size() > 0) ? got[0] : -1, 'h110);
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         chk($sformatf("bp_order%0d", i), got[i], expq[i]);
      req_valid = 0; rsp_ready = 1;

      // Reset with a stalled result pending
      req_valid = 1; req_pid = 0; req_addr = 'h005; rsp_ready = 0;
      tick("prerst");
      req_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("mrst_rsp_valid", rsp_valid, 0);
      chk("mrst_rsp_addr", rsp_addr, 0);
      chk("mrst_rsp_fault", rsp_fault, 0);
      chk("mrst_flt_sticky", flt_sticky, 0);
      chk("mrst_flt_pid", flt_pid, 0);
      chk("mrst_req_ready", req_ready, 1);
      model_reset();
      @(negedge clk);
      rst_n = 1; rsp_ready = 1;
      req_valid = 1; req_pid = 1; req_addr = 'h010;
      tick("postrst");
      chk("postrst_table", rsp_addr, 'h010);
      req_valid = 0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cfg_we    = ($urandom_range(0, 9) == 0);
         cfg_pid   = PID_W'($urandom);
         cfg_base  = ADDR_W'($urandom);
         cfg_limit = ADDR_W'($urandom_range(32'h80, 32'h1FF));
         req_valid = ($urandom_range(0, 3) != 0);
         req_pid   = PID_W'($urandom);
         req_addr  = ADDR_W'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         flt_clr   = ($urandom_range(0, 15) == 0);
         tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
